// File: rtl/lsq_pkg.sv
// Shared load/store-queue definitions: concrete entry layouts and default depths.
package lsq_pkg;

  localparam int LSQ_DEPTH    = 8;
  localparam int LD_LSQ_DEPTH = LSQ_DEPTH;
  localparam int ST_LSQ_DEPTH = LSQ_DEPTH;

  typedef struct packed {
    logic        addr_valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [5:0]  rob_idx;
    logic        done;
  } ld_entry_t;

  typedef struct packed {
    logic        addr_valid;
    logic        data_valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [5:0]  rob_idx;
  } st_entry_t;

endpackage

// File: rtl/lsq_circ_if.sv
// Enqueue/dequeue handshake bundle between dispatch/commit and the circular queue.
interface lsq_circ_if #(
  parameter int  N_ENTRIES = 8,
  parameter type ENTRY_T   = logic [31:0]
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic             enq_ready;
  logic             enq_valid;
  ENTRY_T           enq_data;
  logic [IDX_W-1:0] enq_idx;
  logic             deq_ready;
  logic             deq_valid;
  ENTRY_T           deq_data;

  modport master (
    output enq_valid, enq_data, deq_valid,
    input  enq_ready, enq_idx, deq_ready, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_valid,
    output enq_ready, enq_idx, deq_ready, deq_data
  );
endinterface

// File: rtl/lsq_ptr.sv
// Wrapping queue pointer: the MSB is the wrap bit, so a plain increment wraps the index and toggles it.
module lsq_ptr #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  // Load (flush / partial-flush rewind) takes precedence over a normal advance.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (incr) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/lsq_circ.sv
// Circular load/store queue with per-slot valid bits, in-place update and younger-than flush.
module lsq_circ
  import lsq_pkg::*;
#(
  parameter int  N_ENTRIES = LSQ_DEPTH,
  parameter type ENTRY_T   = logic [31:0],
  parameter int  IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pflush_valid,
  input  logic [IDX_W-1:0]           pflush_idx,
  lsq_circ_if.slave                  io,
  input  logic [N_ENTRIES-1:0]       wr_en,
  input  ENTRY_T [N_ENTRIES-1:0]     wr_data,
  output ENTRY_T [N_ENTRIES-1:0]     entries,
  output logic [N_ENTRIES-1:0]       entry_valid,
  output logic [IDX_W-1:0]           head_idx,
  output logic [IDX_W-1:0]           tail_idx,
  output logic [IDX_W:0]             count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]       head_ptr, tail_ptr, pflush_tail, tail_load_val;
  logic [IDX_W-1:0]       keep_span;
  logic [N_ENTRIES-1:0]   keep_mask;
  logic                   pflush_fire, enq_fire, deq_fire;
  ENTRY_T [N_ENTRIES-1:0] entries_d, entries_q;
  logic [N_ENTRIES-1:0]   valid_d, valid_q;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);
  assign count    = tail_ptr - head_ptr;

  assign io.enq_ready = !full;
  assign io.deq_ready = !empty;
  assign io.enq_idx   = tail_idx;
  assign io.deq_data  = entries_q[head_idx];

  assign entries     = entries_q;
  assign entry_valid = valid_q;

  // Full flush masks everything else; a partial flush masks only the same-cycle enqueue.
  assign pflush_fire = !flush && pflush_valid && valid_q[pflush_idx];
  assign enq_fire    = !flush && !pflush_fire && io.enq_valid && !full;
  assign deq_fire    = !flush && io.deq_valid && !empty;

  // Survivors run from head up to pflush_idx; measuring from head gives the new tail its correct wrap bit.
  assign keep_span     = pflush_idx - head_idx;
  assign pflush_tail   = head_ptr + PTR_W'(keep_span) + PTR_W'(1);
  assign tail_load_val = flush ? '0 : pflush_tail;

  // Slot i survives a partial flush when its distance from head does not exceed that of pflush_idx.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      keep_mask[i] = ((IDX_W'(i) - head_idx) <= keep_span);
    end
  end

  lsq_ptr #(.PTR_W(PTR_W)) u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .incr     (deq_fire),
    .load     (flush),
    .load_val ('0),
    .ptr      (head_ptr)
  );

  lsq_ptr #(.PTR_W(PTR_W)) u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .incr     (enq_fire),
    .load     (flush || pflush_fire),
    .load_val (tail_load_val),
    .ptr      (tail_ptr)
  );

  // Next slot contents and valid bits; the head update is dropped when that entry retires this cycle.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    if (flush) begin
      entries_d = '0;
      valid_d   = '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (wr_en[i] && valid_q[i]
            && !(deq_fire && (head_idx == IDX_W'(i)))
            && !(pflush_fire && !keep_mask[i])) begin
          entries_d[i] = wr_data[i];
        end
      end
      if (pflush_fire) begin
        valid_d = valid_q & keep_mask;
      end
      if (enq_fire) begin
        entries_d[tail_idx] = io.enq_data;
        valid_d[tail_idx]   = 1'b1;
      end
      if (deq_fire) begin
        valid_d[head_idx] = 1'b0;
      end
    end
  end

  // Slot storage and valid bits with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      valid_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: doc/lsq_circ.md
# lsq_circ

Circular load/store queue with head/tail pointers, occupancy tracking and a ready/valid enqueue/dequeue handshake. It adds partial (younger-than) flush and per-slot valid tracking, which the flat register-array queue lacks. It sits between dispatch (enqueue), the AGU/LSU writeback paths (per-entry in-place update) and commit (dequeue at head). The entry layout is a type parameter, so one block serves load and store queues.

## Interface
- N_ENTRIES, 8, queue depth; power of two, >= 2
- ENTRY_T, logic [31:0], packed entry type
- IDX_W, $clog2(N_ENTRIES), derived slot-index width; not overridden

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  full flush; drops all entries
- pflush_valid  in  1  partial flush request
- pflush_idx  in  IDX_W  last surviving slot; all younger slots are dropped
- enq_ready  out  1  slot available (= !full)
- enq_valid  in  1  enqueue request
- enq_data  in  ENTRY_T  entry to append at tail
- enq_idx  out  IDX_W  slot the current enqueue lands in (= tail_idx)
- deq_ready  out  1  head entry present (= !empty)
- deq_valid  in  1  retire the head entry
- deq_data  out  ENTRY_T  head entry contents
- wr_en  in  N_ENTRIES  per-slot in-place update strobe
- wr_data  in  N_ENTRIES x ENTRY_T  per-slot update data
- entries  out  N_ENTRIES x ENTRY_T  all slot contents
- entry_valid  out  N_ENTRIES  slot occupied
- head_idx, tail_idx  out  IDX_W  oldest slot; next free slot
- count  out  IDX_W+1  occupancy, 0..N_ENTRIES
- full, empty  out  1  count==N_ENTRIES; count==0

## Operation
- Pointers are IDX_W+1 bits wide, and the MSB is the wrap bit. empty = (head==tail). full = index bits equal and wrap bits differ. count = tail - head, modulo 2^(IDX_W+1).
- Enqueue fires when enq_valid & enq_ready. It writes enq_data to slot tail, sets entry_valid[tail] and advances tail by 1, wrapping N_ENTRIES-1 -> 0 with the wrap bit toggled.
- Dequeue fires when deq_valid & deq_ready. It clears entry_valid[head] and advances head. Slot data is left as is.
- deq_valid while empty is ignored, with no pointer change. enq_valid while full is ignored, with no bypass: full blocks enqueue even if a dequeue happens the same cycle.
- In-place update: if wr_en[i] & entry_valid[i], slot i <= wr_data[i]. wr_en to an invalid slot is ignored.
- Simultaneous dequeue and wr_en at head: the write is dropped.
- Simultaneous enqueue and dequeue (neither full nor empty): both apply, and count is unchanged.
- Partial flush, when pflush_valid and entry_valid[pflush_idx]:
  - tail <= the pointer just past pflush_idx, with the wrap bit derived relative to head.
  - entry_valid is cleared for every dropped slot.
  - enqueue in the same cycle is suppressed. A same-cycle dequeue still applies.
  - if pflush_idx==head and a dequeue also fires, the queue becomes empty.
  - pflush_valid with pflush_idx not valid is ignored.
- Priority: rst > flush > pflush > enqueue/dequeue/update.
  - rst and flush both zero pointers, entry_valid and entry data.
  - flush overrides any same-cycle enqueue, dequeue, update or partial flush.

## Timing
- All state is registered on the clk rising edge. Outputs are combinational from registers only. Ready signals do not depend on the same-cycle valid inputs.
- Enqueued data appears in entries/deq_data the cycle after the handshake. count/full/empty/pointers also update the cycle after.
- deq_data reflects the head slot with zero latency. A dequeue in cycle t exposes the next entry in cycle t+1.
- Update latency is 1 cycle.
- Reset and flush values:
  - entries = 0, entry_valid = 0, head_idx = tail_idx = enq_idx = 0, count = 0
  - empty = 1, full = 0, enq_ready = 1, deq_ready = 0, deq_data = 0
- rst asserted mid-operation discards in-flight handshakes of that cycle.

## Structure
- Shared package lsq_pkg holds the concrete LSQ entry typedefs (ld_entry_t, st_entry_t) and LSQ_DEPTH constants. Pointer width is derived locally.
- One sub-module, lsq_ptr: IDX_W+1-bit wrapping pointer register.
  - Inputs: incr and load, with a load value.
  - Instantiated for head and tail.
- Partial-flush tail computation and the valid-mask clear stay in lsq_circ.

## Test plan
- Fill/drain (N=4): reset, then enqueue 0xA0..0xA3. Required: full=1, enq_ready=0, count=4. Then dequeue four times. Required: deq_data reads 0xA0,0xA1,0xA2,0xA3 in order, then empty=1.
- Wrap-around: 6 interleaved enq/deq pairs on N=4. Required: tail_idx walks 0,1,2,3,0,1, count stays 1, and FIFO order is preserved across the wrap.
- Full + simultaneous deq: queue full, enq_valid=1 and deq_valid=1. Required: the dequeue retires the head, the enqueue is dropped, and count goes 4 -> 3.
- Update filter: slots 0,1 valid, wr_en=4'b0110 with 0xBEEF. Required: slot 1 = 0xBEEF, slot 2 unchanged, entry_valid stays 4'b0011.
- Partial flush: head=2, slots 2,3,0 valid, pflush_idx=3 with a same-cycle enq. Required next cycle: tail_idx=0, entry_valid=4'b1100, count=2, enqueue suppressed.
- Flush/reset priority: rst and flush asserted during a simultaneous enq/deq/pflush. Required: all outputs at reset values next cycle, and enq_ready=1.
